// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the KCP53K register-file sequencer: RAM geometry,
// the x0 address and the read-sequencing FSM states.
package regfile_sequencer_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 64;

    localparam logic [RF_AW-1:0] X0_ADDR = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RA   = 3'd1,
        ST_RB   = 3'd2,
        ST_RC   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/rf_bypass_slot.sv
// One source-operand slot: captures RAM read data at its capture state, or a
// write-port value that landed while the RAM read was in flight.
module rf_bypass_slot
    import regfile_sequencer_pkg::*;
#(
    parameter int AW      = RF_AW,
    parameter int DW      = RF_DW,
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    input  logic          arm,
    input  logic          cap,
    input  logic          post,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] data
);

    logic          hit;
    logic          is_zero;
    logic          ovr_flag;
    logic [DW-1:0] ovr_data;

    // wen arrives already filtered, so x0 writes never register as a hit.
    assign hit     = wen && (waddr == addr);
    assign is_zero = ZERO_X0 && (addr == '0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ovr_flag <= 1'b0;
            ovr_data <= '0;
            data     <= '0;
        end else begin
            if (clr) begin
                ovr_flag <= 1'b0;
            end else if (arm && hit) begin
                ovr_flag <= 1'b1;
                ovr_data <= wdata;
            end

            // A write at the capture edge itself is the newest value of all.
            if (cap) begin
                if (is_zero)       data <= '0;
                else if (hit)      data <= wdata;
                else if (ovr_flag) data <= ovr_data;
                else               data <= rdata;
            end else if (post && hit && !is_zero) begin
                data <= wdata;
            end
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences two-source reads over the single registered RAM read port and
// filters/forwards writeback traffic so responses stay coherent.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int AW      = RF_AW,
    parameter int DW      = RF_DW,
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          rd_valid_i,
    output logic          rd_ready_o,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          ram_wen_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [2:0]    dbg_state_o
);

    // Handshakes: a request transfers when rd_valid_i & rd_ready_o at a rising
    // edge, a response retires when rsp_valid_o & rsp_ready_i at a rising edge;
    // rsp_valid_o and the data outputs do not change until retire.

    state_t        state, state_n;
    logic [AW-1:0] rs1_q, rs2_q;
    logic          accept;
    logic          x0_drop;

    assign x0_drop     = ZERO_X0 && (wr_addr_i == '0);
    assign ram_wen_o   = wr_en_i && reset_ni && !x0_drop;
    assign ram_waddr_o = wr_addr_i;
    assign ram_wdata_o = wr_data_i;

    always_comb begin
        state_n     = state;
        rd_ready_o  = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_ready_o = 1'b1;
                if (rd_valid_i) state_n = ST_RA;
            end
            ST_RA:   state_n = ST_RB;
            ST_RB:   state_n = ST_RC;
            ST_RC:   state_n = ST_RESP;
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rd_ready_o  = rsp_ready_i;
                if (rsp_ready_i) state_n = rd_valid_i ? ST_RA : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign accept = rd_valid_i && rd_ready_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_IDLE;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                rs1_q <= rs1_i;
                rs2_q <= rs2_i;
            end
        end
    end

    assign ram_raddr_o = (state == ST_RB) ? rs2_q : rs1_q;
    assign dbg_state_o = state;

    // rs1 is latched by the RAM at the end of RA, rs2 at the end of RB.
    rf_bypass_slot #(.AW(AW), .DW(DW), .ZERO_X0(ZERO_X0)) u_slot_rs1 (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .addr     (rs1_q),
        .clr      (accept),
        .arm      (state == ST_RA),
        .cap      (state == ST_RB),
        .post     (state == ST_RC),
        .wen      (ram_wen_o),
        .waddr    (wr_addr_i),
        .wdata    (wr_data_i),
        .rdata    (ram_rdata_i),
        .data     (rs1_data_o)
    );

    rf_bypass_slot #(.AW(AW), .DW(DW), .ZERO_X0(ZERO_X0)) u_slot_rs2 (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .addr     (rs2_q),
        .clr      (accept),
        .arm      (state == ST_RB),
        .cap      (state == ST_RC),
        .post     (1'b0),
        .wen      (ram_wen_o),
        .waddr    (wr_addr_i),
        .wdata    (wr_data_i),
        .rdata    (ram_rdata_i),
        .data     (rs2_data_o)
    );

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural RAM plus an architectural register
// model, directed scenarios and randomized read/write traffic.
module tb_regfile_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        rd_valid_i = 1'b0;
    logic        rd_ready_o;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rs1_data_o, rs2_data_o;
    logic        wr_en_i = 1'b0;
    logic [4:0]  wr_addr_i = '0;
    logic [63:0] wr_data_i = '0;
    logic        ram_wen_o;
    logic [4:0]  ram_waddr_o, ram_raddr_o;
    logic [63:0] ram_wdata_o;
    logic [63:0] ram_rdata_i;
    logic [2:0]  dbg_state_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] mem    [32];
    logic [63:0] ref_rf [32];

    regfile_sequencer dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .ram_wen_o   (ram_wen_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_rdata_i (ram_rdata_i),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM macro: read-during-write to the same address returns garbage.
    always @(posedge clk_i) begin
        if (ram_wen_o) mem[ram_waddr_o] <= ram_wdata_o;
        if (ram_wen_o && ram_waddr_o == ram_raddr_o) ram_rdata_i <= ~mem[ram_raddr_o];
        else                                         ram_rdata_i <= mem[ram_raddr_o];
    end

    function automatic logic [63:0] model_val(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : ref_rf[a];
    endfunction

    // One clock: the architectural model sees every write accepted at the edge.
    task automatic step();
        @(posedge clk_i);
        if (reset_ni && wr_en_i && wr_addr_i != 5'd0) ref_rf[wr_addr_i] = wr_data_i;
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [63:0] d);
        wr_en_i = en; wr_addr_i = a; wr_data_i = d;
    endtask

    task automatic rand_wr(input logic [4:0] a1, input logic [4:0] a2);
        logic [4:0] a;
        case ($urandom_range(0, 3))
            0: a = a1;
            1: a = a2;
            2: a = 5'd0;
            default: a = 5'($urandom_range(0, 31));
        endcase
        set_wr(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    endtask

    // Full request: accept, 3-edge latency, stall in RESP, retire alone.
    task automatic run_txn(input logic [4:0] a1, input logic [4:0] a2,
                           input int stall, input bit rnd);
        logic [63:0] e1, e2;
        if (rd_ready_o !== 1'b1) begin
            $display("FAIL txn_ready_idle: rd_ready_o=%b want 1", rd_ready_o); tests_failed++;
        end
        tests_run++;
        rd_valid_i = 1'b1; rs1_i = a1; rs2_i = a2;
        if (rnd) rand_wr(a1, a2); else set_wr(1'b0, '0, '0);
        step();
        rd_valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (rnd) rand_wr(a1, a2); else set_wr(1'b0, '0, '0);
            step();
            if (rsp_valid_o !== (k == 3)) begin
                $display("FAIL txn_latency: edge %0d rsp_valid_o=%b want %b", k, rsp_valid_o, k == 3);
                tests_failed++;
            end
            tests_run++;
        end
        e1 = model_val(a1);
        e2 = model_val(a2);
        if (rs1_data_o !== e1 || rs2_data_o !== e2) begin
            $display("FAIL txn_data: rs%0d/rs%0d got %h/%h want %h/%h", a1, a2, rs1_data_o, rs2_data_o, e1, e2);
            tests_failed++;
        end
        tests_run++;
        rsp_ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (rnd) rand_wr(a1, a2); else set_wr(1'b0, '0, '0);
            step();
            if (rsp_valid_o !== 1'b1 || rd_ready_o !== 1'b0 || rs1_data_o !== e1 || rs2_data_o !== e2) begin
                $display("FAIL txn_hold: valid=%b ready=%b data %h/%h want 1/0 %h/%h",
                         rsp_valid_o, rd_ready_o, rs1_data_o, rs2_data_o, e1, e2);
                tests_failed++;
            end
            tests_run++;
        end
        rsp_ready_i = 1'b1;
        set_wr(1'b0, '0, '0);
        step();
        rsp_ready_i = 1'b0;
        if (rsp_valid_o !== 1'b0) begin
            $display("FAIL txn_retire: rsp_valid_o=%b want 0", rsp_valid_o); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        set_wr(1'b1, 5'd3, 64'h1234);
        #1;
        if (ram_wen_o !== 1'b0) begin
            $display("FAIL reset_wen: ram_wen_o=%b want 0", ram_wen_o); tests_failed++;
        end
        tests_run++;
        step(); step();
        if (rsp_valid_o !== 1'b0 || rd_ready_o !== 1'b1 || rs1_data_o !== 64'd0 ||
            rs2_data_o !== 64'd0 || ram_raddr_o !== 5'd0 || dbg_state_o !== 3'd0) begin
            $display("FAIL reset_state: valid=%b ready=%b d=%h/%h raddr=%0d st=%0d want 0/1/0/0/0/0",
                     rsp_valid_o, rd_ready_o, rs1_data_o, rs2_data_o, ram_raddr_o, dbg_state_o);
            tests_failed++;
        end
        tests_run++;
        set_wr(1'b0, '0, '0);
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_wr(1'b1, 5'd5, 64'h1122334455667788);
        step();
        run_txn(5'd5, 5'd0, 0, 1'b0);
        if (ref_rf[5] !== 64'h1122334455667788) begin
            $display("FAIL basic_model: x5=%h want 1122334455667788", ref_rf[5]); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_x0_write();
        set_wr(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        if (ram_wen_o !== 1'b0) begin
            $display("FAIL x0_wen: ram_wen_o=%b want 0", ram_wen_o); tests_failed++;
        end
        tests_run++;
        step();
        run_txn(5'd0, 5'd0, 1, 1'b0);
    endtask

    task automatic test_forwarding();
        rd_valid_i = 1'b1; rs1_i = 5'd7; rs2_i = 5'd7;
        set_wr(1'b0, '0, '0);
        step();                               // E0
        rd_valid_i = 1'b0;
        if (ram_raddr_o !== 5'd7) begin
            $display("FAIL fwd_raddr: ram_raddr_o=%0d want 7", ram_raddr_o); tests_failed++;
        end
        tests_run++;
        set_wr(1'b1, 5'd7, 64'hA5);
        step();                               // E1 collision
        set_wr(1'b0, '0, '0);
        step();                               // E2
        set_wr(1'b1, 5'd7, 64'h5A);
        step();                               // E3
        set_wr(1'b0, '0, '0);
        if (rsp_valid_o !== 1'b1 || rs1_data_o !== 64'h5A || rs2_data_o !== 64'h5A) begin
            $display("FAIL fwd_data: valid=%b d=%h/%h want 1 5a/5a", rsp_valid_o, rs1_data_o, rs2_data_o);
            tests_failed++;
        end
        tests_run++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_txn(5'd7, 5'd7, 0, 1'b0);
        rd_valid_i = 1'b1; rs1_i = 5'd7; rs2_i = 5'd7;
        step(); rd_valid_i = 1'b0; step(); step(); step();
        // now in RESP holding x7; stall while x7 is rewritten
        for (int s = 0; s < 5; s++) begin
            set_wr(1'b1, 5'd7, 64'h33);
            step();
            if (rsp_valid_o !== 1'b1 || rd_ready_o !== 1'b0 || rs1_data_o !== 64'h5A || rs2_data_o !== 64'h5A) begin
                $display("FAIL bp_hold: valid=%b ready=%b d=%h/%h want 1/0 5a/5a",
                         rsp_valid_o, rd_ready_o, rs1_data_o, rs2_data_o);
                tests_failed++;
            end
            tests_run++;
        end
        set_wr(1'b0, '0, '0);
        rsp_ready_i = 1'b1; rd_valid_i = 1'b1;
        #1;
        if (rd_ready_o !== 1'b1) begin
            $display("FAIL bp_ready: rd_ready_o=%b want 1", rd_ready_o); tests_failed++;
        end
        tests_run++;
        step();
        rsp_ready_i = 1'b0; rd_valid_i = 1'b0;
        if (rsp_valid_o !== 1'b0) begin
            $display("FAIL bp_retire: rsp_valid_o=%b want 0", rsp_valid_o); tests_failed++;
        end
        tests_run++;
        step(); step(); step();
        if (rsp_valid_o !== 1'b1 || rs1_data_o !== 64'h33 || rs2_data_o !== 64'h33) begin
            $display("FAIL bp_next: valid=%b d=%h/%h want 1 33/33", rsp_valid_o, rs1_data_o, rs2_data_o);
            tests_failed++;
        end
        tests_run++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_midop_reset();
        set_wr(1'b1, 5'd5, 64'hCAFE_0005); step();
        set_wr(1'b1, 5'd7, 64'hCAFE_0007); step();
        set_wr(1'b0, '0, '0);
        rd_valid_i = 1'b1; rs1_i = 5'd5; rs2_i = 5'd7;
        step(); rd_valid_i = 1'b0; step();      // in RB
        reset_ni = 1'b0;
        set_wr(1'b1, 5'd5, 64'hDEAD);
        #1;
        if (rsp_valid_o !== 1'b0 || dbg_state_o !== 3'd0 || ram_wen_o !== 1'b0) begin
            $display("FAIL midreset: valid=%b st=%0d wen=%b want 0/0/0", rsp_valid_o, dbg_state_o, ram_wen_o);
            tests_failed++;
        end
        tests_run++;
        step();
        set_wr(1'b0, '0, '0);
        reset_ni = 1'b1;
        step();
        run_txn(5'd5, 5'd7, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                rand_wr(5'd0, 5'd0);
                step();
            end
            run_txn(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]    = {$urandom, $urandom};
            ref_rf[i] = mem[i];
        end
        test_reset();
        test_basic();
        test_x0_write();
        test_forwarding();
        test_back_to_back();
        test_midop_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
